// File: rtl/led_pwm_fader_pkg.sv
// Shared constants and helpers for the LED PWM fader and its per-channel slice.
package led_pwm_fader_pkg;

    // Default geometry, matching the firefly LED core's output pattern width.
    localparam int LED_CH       = 8;
    localparam int LED_PWM_BITS = 8;

    // Direction a channel's brightness moves on a fade tick.
    typedef enum logic [1:0] {
        FADE_HOLD = 2'b00,
        FADE_UP   = 2'b01,
        FADE_DOWN = 2'b10
    } fade_dir_e;

    // Full-scale brightness / PWM count for a given counter width.
    function automatic int pwm_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: saturating brightness ramp, period-aligned duty shadow and
// registered PWM compare.
module led_pwm_channel
    import led_pwm_fader_pkg::*;
#(
    parameter int PWM_BITS = LED_PWM_BITS,
    parameter int STEP     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                target_bit,
    output logic                pwm,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] MAX      = PWM_BITS'(pwm_max(PWM_BITS));
    localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS + 1)'(STEP);
    localparam logic [PWM_BITS:0]   MAX_EXT  = {1'b0, MAX};

    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pwm_q, pwm_d;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS:0]   sum_up;
    logic [PWM_BITS:0]   diff_down;
    fade_dir_e           dir;

    // Fade step, duty shadow and compare; one extra bit catches overflow/borrow.
    always_comb begin
        target    = target_bit ? MAX : '0;
        sum_up    = {1'b0, bright_q} + STEP_EXT;
        diff_down = {1'b0, bright_q} - STEP_EXT;

        if (bright_q < target) begin
            dir = FADE_UP;
        end else if (bright_q > target) begin
            dir = FADE_DOWN;
        end else begin
            dir = FADE_HOLD;
        end

        bright_d = bright_q;
        if (tick) begin
            case (dir)
                FADE_UP:   bright_d = (sum_up > MAX_EXT) ? MAX : sum_up[PWM_BITS-1:0];
                FADE_DOWN: bright_d = diff_down[PWM_BITS] ? '0 : diff_down[PWM_BITS-1:0];
                default:   bright_d = bright_q;
            endcase
        end

        // Capture the pre-tick brightness so a new duty only starts at count 0.
        duty_d = wrap ? bright_q : duty_q;

        // Full scale is forced high so the output never dips for one count.
        pwm_d = (duty_q == MAX) ? 1'b1 : (pwm_cnt < duty_q);

        busy = (bright_d != target);
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bright_q <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
        end else begin
            bright_q <= bright_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/led_pwm_fader.sv
// LED PWM fader: turns an on/off LED pattern into smoothly ramped, glitch-free
// PWM drive. Owns the input register, prescaler, PWM counter and status flags.
module led_pwm_fader
    import led_pwm_fader_pkg::*;
#(
    parameter int CH       = LED_CH,
    parameter int PWM_BITS = LED_PWM_BITS,
    parameter int PRESCALE = 16,
    parameter int STEP     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] led_in,
    output logic [CH-1:0] pwm_out,
    output logic          period_start,
    output logic          fade_busy
);

    localparam int                PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);

    logic [CH-1:0]       led_q, led_d;
    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                period_start_q, period_start_d;
    logic                fade_busy_q, fade_busy_d;
    logic                tick;
    logic                wrap;
    logic [CH-1:0]       ch_busy;

    // Shared timebase: fade tick, free-running PWM count and status flags.
    always_comb begin
        led_d          = led_in;
        tick           = (presc_q == PS_LAST);
        presc_d        = tick ? '0 : presc_q + 1'b1;
        wrap           = (pwm_cnt_q == '1);
        pwm_cnt_d      = pwm_cnt_q + 1'b1;
        period_start_d = (pwm_cnt_q == '0);
        fade_busy_d    = |ch_busy;
    end

    // Top-level registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            led_q          <= '0;
            presc_q        <= '0;
            pwm_cnt_q      <= '0;
            period_start_q <= 1'b0;
            fade_busy_q    <= 1'b0;
        end else begin
            led_q          <= led_d;
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
            fade_busy_q    <= fade_busy_d;
        end
    end

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            led_pwm_channel #(
                .PWM_BITS (PWM_BITS),
                .STEP     (STEP)
            ) u_ch (
                .clk        (clk),
                .reset      (reset),
                .tick       (tick),
                .wrap       (wrap),
                .pwm_cnt    (pwm_cnt_q),
                .target_bit (led_q[gi]),
                .pwm        (pwm_out[gi]),
                .busy       (ch_busy[gi])
            );
        end
    endgenerate

    assign period_start = period_start_q;
    assign fade_busy    = fade_busy_q;

endmodule
